// File: rtl/kiss99_index_source_if.sv
// kiss99_index_source_if: seed load, index request and result handshakes.
// Signals: seed_*, req_valid/req_ready/req_len, idx_valid/idx_ready/idx/raw/len_err.
interface kiss99_index_source_if;
  logic        seed_valid;
  logic [31:0] seed_z;
  logic [31:0] seed_w;
  logic [31:0] seed_jsr;
  logic [31:0] seed_jcong;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_len;
  logic        idx_valid;
  logic        idx_ready;
  logic [31:0] idx;
  logic [31:0] raw;
  logic        len_err;

  modport master (
    output seed_valid, seed_z, seed_w,
    output seed_jsr, seed_jcong,
    output req_valid, req_len, idx_ready,
    input  req_ready, idx_valid, idx,
    input  raw, len_err
  );

  modport slave (
    input  seed_valid, seed_z, seed_w,
    input  seed_jsr, seed_jcong,
    input  req_valid, req_len, idx_ready,
    output req_ready, idx_valid, idx,
    output raw, len_err
  );
endinterface

// File: rtl/kiss99_index_source.sv
// kiss99_index_source: ProgPoW KISS99 word generator reduced mod req_len.
// Ports: clk, rst_n (async low), bus (slave modport of kiss99_index_source_if).
// Option: KISS99_IDX_POW2_FAST_EN masks power-of-two lengths in GEN.
module kiss99_index_source (
  input logic                   clk,
  input logic                   rst_n,
  kiss99_index_source_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DIV,
    OUT
  } state_t;

  state_t      state;
  logic [31:0] z, w, jsr, jcong;
  logic [31:0] len_q;
  logic [31:0] dq;
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic [31:0] idx_q, raw_q;
  logic        err_q, valid_q;

  logic [31:0] z_n, w_n, mwc;
  logic [31:0] j1, j2, jsr_n, jc_n;
  logic [31:0] raw_n;
  logic [32:0] trial, diff;

  always_comb begin
    z_n   = 32'd36969 * {16'd0, z[15:0]}
          + {16'd0, z[31:16]};
    w_n   = 32'd18000 * {16'd0, w[15:0]}
          + {16'd0, w[31:16]};
    mwc   = {z_n[15:0], 16'd0} + w_n;
    j1    = jsr ^ (jsr << 17);
    j2    = j1 ^ (j1 >> 13);
    jsr_n = j2 ^ (j2 << 5);
    jc_n  = 32'd69069 * jcong + 32'd1234567;
    raw_n = (mwc ^ jc_n) + jsr_n;
  end

  // 33-bit trial remainder; diff[32] set means a borrow.
  always_comb begin
    trial = {rem, dq[31]};
    diff  = trial - {1'b0, len_q};
  end

  assign bus.req_ready = (state == IDLE)
                       && !bus.seed_valid;
  assign bus.idx_valid = valid_q;
  assign bus.idx       = idx_q;
  assign bus.raw       = raw_q;
  assign bus.len_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      z       <= 32'd362436069;
      w       <= 32'd521288629;
      jsr     <= 32'd123456789;
      jcong   <= 32'd380116160;
      len_q   <= '0;
      dq      <= '0;
      rem     <= '0;
      cnt     <= '0;
      idx_q   <= '0;
      raw_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.seed_valid) begin
      z       <= bus.seed_z;
      w       <= bus.seed_w;
      jsr     <= bus.seed_jsr;
      jcong   <= bus.seed_jcong;
      valid_q <= 1'b0;
      state   <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            len_q <= bus.req_len;
            state <= GEN;
          end
        end
        GEN: begin
          z     <= z_n;
          w     <= w_n;
          jsr   <= jsr_n;
          jcong <= jc_n;
          raw_q <= raw_n;
          dq    <= raw_n;
          rem   <= '0;
          cnt   <= '0;
          err_q <= 1'b0;
          if (len_q == '0) begin
            idx_q   <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state   <= OUT;
          end
`ifdef KISS99_IDX_POW2_FAST_EN
          else if ((len_q & (len_q - 32'd1)) == '0) begin
            idx_q   <= raw_n & (len_q - 32'd1);
            valid_q <= 1'b1;
            state   <= OUT;
          end
`endif
          else begin
            state <= DIV;
          end
        end
        DIV: begin
          dq  <= {dq[30:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            idx_q   <= diff[32] ? trial[31:0]
                                : diff[31:0];
            valid_q <= 1'b1;
            state   <= OUT;
          end else begin
            rem <= diff[32] ? trial[31:0]
                            : diff[31:0];
          end
        end
        OUT: begin
          if (bus.idx_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
